// File: rtl/uart_imem_boot_loader_pkg.sv
// Shared types and defaults for the UART instruction-memory boot loader.
package uart_imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_REPLY  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  // A count of exactly 2**addr_w words fills imem completely and is still legal.
  function automatic logic count_too_big(input logic [15:0] count, input int addr_w);
    return ({1'b0, count} > (17'd1 << addr_w));
  endfunction

endpackage

// File: rtl/uart_imem_boot_loader_if.sv
// UART byte stream, imem write port and boot status bundled as one port.
interface uart_imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              boot_done;
  logic              boot_error;

  // loader side
  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, imem_we, imem_addr, imem_wdata,
           core_hold, boot_done, boot_error
  );

  // UART / memory / core side
  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, imem_we, imem_addr, imem_wdata,
           core_hold, boot_done, boot_error
  );
endinterface

// File: rtl/uart_imem_boot_loader_word_packer.sv
// Packs four consecutive bytes LSB-first into a 32-bit word.
// word/word_ready are valid in the same cycle as the 4th byte so the
// caller can register the imem write one cycle after that byte.
module uart_imem_boot_loader_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt;
  logic [23:0] sreg;

  assign word_ready = byte_valid && (byte_cnt == 2'd3);
  assign word       = {byte_data, sreg};

  // Shift bytes in from the top so the first byte ends up in bits [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      sreg     <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      sreg     <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      sreg     <= {byte_data, sreg[23:8]};
    end
  end

endmodule

// File: rtl/uart_imem_boot_loader.sv
// Boot loader: receives SYNC, 16-bit word count, data words and an XOR
// checksum over UART, writes the words to imem, replies ACK/NAK and
// releases the core only after a verified image.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for the sync byte
// CNT_LO   | expecting count[7:0]
// CNT_HI   | expecting count[15:8], range-checked here
// DATA     | packing data bytes, one imem write per word
// CSUM     | expecting checksum byte
// REPLY    | holding ACK/NAK on tx until accepted
// DONE     | image verified, core released, rx ignored
module uart_imem_boot_loader
  import uart_imem_boot_loader_pkg::*;
#(
  parameter int         ADDR_W      = 10,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_imem_boot_loader_if.master  bus
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);

  state_t            state;
  logic [7:0]        count_lo;
  logic [15:0]       count_rx;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        csum;
  logic              reply_ok;
  logic [TO_W-1:0]   to_cnt;
  logic              in_frame;
  logic              timed_out;
  logic [31:0]       word;
  logic              word_ready;

  assign in_frame  = state inside {S_CNT_LO, S_CNT_HI, S_DATA, S_CSUM};
  // A byte arriving on the would-be timeout cycle keeps the frame alive.
  assign timed_out = in_frame && !bus.rx_valid && (to_cnt >= TO_LAST);
  assign count_rx  = {bus.rx_data, count_lo};

  uart_imem_boot_loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (state != S_DATA),
    .byte_valid (bus.rx_valid && (state == S_DATA)),
    .byte_data  (bus.rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Inter-byte idle counter, only live while a frame is in progress; saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!in_frame || bus.rx_valid) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Frame FSM with registered tx, imem and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      count_lo       <= 8'd0;
      words_left     <= 16'd0;
      wr_addr        <= '0;
      csum           <= 8'd0;
      reply_ok       <= 1'b0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= 8'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      bus.core_hold  <= 1'b1;
      bus.boot_done  <= 1'b0;
      bus.boot_error <= 1'b0;
    end else begin
      bus.imem_we    <= 1'b0;
      bus.boot_error <= 1'b0;
      if (timed_out) begin
        state        <= S_REPLY;
        reply_ok     <= 1'b0;
        bus.tx_valid <= 1'b1;
        bus.tx_data  <= NAK_BYTE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) state <= S_CNT_LO;
          end
          S_CNT_LO: begin
            if (bus.rx_valid) begin
              count_lo <= bus.rx_data;
              state    <= S_CNT_HI;
            end
          end
          S_CNT_HI: begin
            if (bus.rx_valid) begin
              words_left <= count_rx;
              wr_addr    <= '0;
              csum       <= 8'd0;
              if (count_too_big(count_rx, ADDR_W)) begin
                state        <= S_REPLY;
                reply_ok     <= 1'b0;
                bus.tx_valid <= 1'b1;
                bus.tx_data  <= NAK_BYTE;
              end else if (count_rx == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (bus.rx_valid) begin
              csum <= csum ^ bus.rx_data;
              if (word_ready) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= wr_addr;
                bus.imem_wdata <= word;
                wr_addr        <= wr_addr + ADDR_W'(1);
                words_left     <= words_left - 16'd1;
                if (words_left == 16'd1) state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (bus.rx_valid) begin
              state        <= S_REPLY;
              reply_ok     <= (bus.rx_data == csum);
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= (bus.rx_data == csum) ? ACK_BYTE : NAK_BYTE;
            end
          end
          S_REPLY: begin
            if (bus.tx_ready) begin
              bus.tx_valid <= 1'b0;
              if (reply_ok) begin
                state         <= S_DONE;
                bus.core_hold <= 1'b0;
                bus.boot_done <= 1'b1;
              end else begin
                state          <= S_IDLE;
                bus.boot_error <= 1'b1;
              end
            end
          end
          S_DONE: begin
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_boot_loader.sv
// Directed bench for the UART boot loader with a frame-level reference model.
module tb_uart_imem_boot_loader;

  localparam int         ADDR_W = 10;
  localparam int         TO     = 50;
  localparam int         MAXW   = 1 << ADDR_W;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          tx_xfers = 0;
  wr_t         exp_wr[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] shadow [0:MAXW-1];
  logic        exp_done = 1'b0;
  logic        exp_err  = 1'b0;
  logic        ack_pend = 1'b0;
  logic        nak_pend = 1'b0;
  logic        tx_stall = 1'b0;
  logic [7:0]  stall_data = 8'd0;
  wr_t         cmp_e;
  logic [7:0]  cmp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // XOR of the data bytes of a frame (bytes after the 3-byte header).
  function automatic logic [7:0] xor_data(input bq_t f);
    logic [7:0] c = 8'd0;
    int cnt = int'(f[1]) + 256 * int'(f[2]);
    for (int i = 0; i < 4 * cnt && 3 + i < f.size(); i++) c ^= f[3 + i];
    return c;
  endfunction

  // Frame-level model: which words land where, and what the reply must be.
  task automatic model_frame(input bq_t f);
    int cnt = int'(f[1]) + 256 * int'(f[2]);
    if (cnt > MAXW) begin
      exp_tx.push_back(NAK);
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      wr_t e;
      e.addr = w;
      e.data = {f[3+4*w+3], f[3+4*w+2], f[3+4*w+1], f[3+4*w]};
      exp_wr.push_back(e);
    end
    exp_tx.push_back((f[3+4*cnt] == xor_data(f)) ? ACK : NAK);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_xfers(input int target, input string name);
    int k = 0;
    while (tx_xfers < target && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(tx_xfers >= target), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_wr.delete();
    exp_tx.delete();
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"},   bus.tx_valid,   0);
    check({tag, "_tx_data"},    bus.tx_data,    0);
    check({tag, "_imem_we"},    bus.imem_we,    0);
    check({tag, "_imem_addr"},  bus.imem_addr,  0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 0);
    check({tag, "_core_hold"},  bus.core_hold,  1);
    check({tag, "_boot_done"},  bus.boot_done,  0);
    check({tag, "_boot_error"}, bus.boot_error, 0);
  endtask

  // Every-cycle comparison of DUT outputs against the model's expectations.
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 1'b0;
      ack_pend = 1'b0;
      nak_pend = 1'b0;
      tx_stall = 1'b0;
    end else begin
      if (ack_pend) exp_done = 1'b1;
      exp_err  = nak_pend;
      ack_pend = 1'b0;
      nak_pend = 1'b0;
      check("boot_done", bus.boot_done, exp_done);
      check("core_hold", bus.core_hold, !exp_done);
      check("boot_error", bus.boot_error, exp_err);
      if (tx_stall) begin
        check("tx_valid_held", bus.tx_valid, 1);
        check("tx_data_held", bus.tx_data, stall_data);
      end
      if (bus.imem_we) begin
        if (exp_wr.size() == 0) flag("unexpected_write");
        else begin
          cmp_e = exp_wr.pop_front();
          check("imem_addr", bus.imem_addr, cmp_e.addr);
          check("imem_wdata", bus.imem_wdata, cmp_e.data);
        end
        shadow[bus.imem_addr] = bus.imem_wdata;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_xfers++;
        if (exp_tx.size() == 0) flag("unexpected_reply");
        else begin
          cmp_t = exp_tx.pop_front();
          check("tx_reply", bus.tx_data, cmp_t);
          if (cmp_t == ACK) ack_pend = 1'b1;
          else nak_pend = 1'b1;
        end
      end
      tx_stall   = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t        f;
    bq_t        good;
    logic [7:0] c;
    logic [31:0] w;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.tx_ready = 1'b1;
    #1 reset = 1'b1;
    #1 check_reset_outputs("rst");
    idle(2);
    reset = 1'b0;
    idle(1);
    check_reset_outputs("post_rst");

    // 1: good two-word frame
    good = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    check("model_csum_t1", xor_data(good), 8'h88);
    model_frame(good);
    for (int i = 0; i < good.size(); i++) begin
      send_byte(good[i]);
      if (i == 5) check("t1_we_early", bus.imem_we, 0);
      if (i == 6) begin
        check("t1_we_latency", bus.imem_we, 1);
        check("t1_addr0", bus.imem_addr, 0);
        check("t1_word0", bus.imem_wdata, 32'h44332211);
      end
    end
    wait_xfers(1, "t1_reply");
    idle(2);
    check("t1_shadow0", shadow[0], 32'h44332211);
    check("t1_shadow1", shadow[1], 32'h88776655);
    check("t1_done", bus.boot_done, 1);
    check("t1_hold", bus.core_hold, 0);

    // 2: bad checksum, then resend the good frame
    do_reset();
    f = good;
    f[11] = 8'h09;
    model_frame(f);
    send_frame(f);
    wait_xfers(2, "t2_reply");
    check("t2_error_pulse", bus.boot_error, 1);
    check("t2_hold", bus.core_hold, 1);
    idle(1);
    check("t2_error_cleared", bus.boot_error, 0);
    model_frame(good);
    send_frame(good);
    wait_xfers(3, "t2_resend_reply");
    idle(2);
    check("t2_done", bus.boot_done, 1);

    // 3: empty image, oversize count, full-size image
    do_reset();
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_frame(f);
    send_frame(f);
    wait_xfers(4, "t3_empty_reply");
    idle(2);
    check("t3_empty_done", bus.boot_done, 1);
    do_reset();
    f = '{8'hA5, 8'h01, 8'h04};
    model_frame(f);
    send_frame(f);
    check("t3_immediate_nak_valid", bus.tx_valid, 1);
    check("t3_immediate_nak_data", bus.tx_data, NAK);
    wait_xfers(5, "t3_oversize_reply");
    f = '{8'hA5, 8'h00, 8'h04};
    c = 8'd0;
    for (int i = 0; i < MAXW; i++) begin
      w = (i * 32'h00010001) ^ 32'hA5A50000;
      for (int b = 0; b < 4; b++) begin
        f.push_back(w[8*b +: 8]);
        c ^= w[8*b +: 8];
      end
    end
    f.push_back(c);
    model_frame(f);
    send_frame(f);
    wait_xfers(6, "t3_full_reply");
    idle(2);
    check("t3_full_last", shadow[1023], 32'hA65A03FF);
    check("t3_full_mid", shadow[512], 32'hA7A50200);
    check("t3_full_done", bus.boot_done, 1);

    // 4: inter-byte timeout, and a byte just before the limit
    do_reset();
    exp_tx.push_back(NAK);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    bus.tx_ready = 1'b0;
    idle(49);
    check("t4_no_early_nak", bus.tx_valid, 0);
    idle(1);
    check("t4_nak_valid", bus.tx_valid, 1);
    check("t4_nak_data", bus.tx_data, NAK);
    bus.tx_ready = 1'b1;
    wait_xfers(7, "t4_timeout_reply");
    f = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    check("model_csum_t4", xor_data(f), 8'h44);
    model_frame(f);
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22});
    idle(49);
    send_byte(8'h33);
    idle(49);
    send_byte(8'h44);
    send_byte(8'h44);
    wait_xfers(8, "t4_late_byte_reply");
    idle(2);
    check("t4_done", bus.boot_done, 1);

    // 5: reply back-pressure, rx ignored in REPLY and DONE
    do_reset();
    bus.tx_ready = 1'b0;
    model_frame(good);
    send_frame(good);
    for (int i = 0; i < 20; i++) send_byte((i % 4 == 0) ? 8'hA5 : 8'h00);
    check("t5_held_valid", bus.tx_valid, 1);
    check("t5_held_data", bus.tx_data, ACK);
    bus.tx_ready = 1'b1;
    wait_xfers(9, "t5_reply");
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00});
    idle(5);
    check("t5_done_silent", bus.tx_valid, 0);
    check("t5_done", bus.boot_done, 1);

    // 6: asynchronous reset in the middle of DATA
    do_reset();
    send_frame('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
    check("t6_word_written", bus.imem_wdata, 32'h44332211);
    #2 reset = 1'b1;
    #1 check_reset_outputs("t6");
    exp_wr.delete();
    exp_tx.delete();
    idle(2);
    reset = 1'b0;
    idle(1);
    send_byte(8'h33);
    model_frame(good);
    send_frame(good);
    wait_xfers(10, "t6_reply");
    idle(2);
    check("t6_done", bus.boot_done, 1);

    check("leftover_writes", exp_wr.size(), 0);
    check("leftover_replies", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
